// File: rtl/sccb_pkg.sv
`default_nettype none
// ============================================================================
// Module : sccb_pkg
// Brief  : Shared types, constants and bus-level decode for the SCCB writer
// Rev    : 1.0
// ============================================================================
package sccb_pkg;

    localparam int         FRAME_W    = 27;
    localparam int         BIT_CNT_W  = 5;
    localparam logic [7:0] DEF_DEV_ID = 8'h42;

    typedef enum logic [2:0] {
        ST_PWRUP = 3'd0,
        ST_LOAD  = 3'd1,
        ST_START = 3'd2,
        ST_SHIFT = 3'd3,
        ST_ACK   = 3'd4,
        ST_STOP  = 3'd5,
        ST_GAP   = 3'd6,
        ST_DONE  = 3'd7
    } state_e;

    // Frame positions 8, 17 and 26 are the don't-care ACK slots.
    function automatic logic is_ack_slot(input logic [BIT_CNT_W-1:0] n);
        return (n == 5'd8) || (n == 5'd17) || (n == 5'd26);
    endfunction

    // Returns {sio_c, sio_d_oe} for a state and quarter; sda_bit is the frame MSB.
    function automatic logic [1:0] bus_levels(input state_e     st,
                                              input logic [1:0] q,
                                              input logic       sda_bit);
        logic [1:0] lv;
        lv = 2'b10;
        case (st)
            ST_START: begin
                case (q)
                    2'd1:    lv = 2'b11;
                    2'd2:    lv = 2'b01;
                    default: lv = 2'b10;
                endcase
            end
            ST_SHIFT: lv = {(q == 2'd1) || (q == 2'd2), ~sda_bit};
            ST_ACK:   lv = {(q == 2'd1) || (q == 2'd2), 1'b0};
            ST_STOP: begin
                case (q)
                    2'd0:    lv = 2'b01;
                    2'd1:    lv = 2'b11;
                    default: lv = 2'b10;
                endcase
            end
            default: lv = 2'b10;
        endcase
        return lv;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sccb_config_writer_if.sv
`default_nettype none
// ============================================================================
// Module : sccb_config_writer_if
// Brief  : LUT address/data and SCCB bus lines of the config writer
// Rev    : 1.0
// ============================================================================
interface sccb_config_writer_if;

    logic [7:0]  lut_index;
    logic [15:0] lut_data;
    logic        sio_c;
    logic        sio_d_oe;

    modport master (
        output lut_index,
        input  lut_data,
        output sio_c,
        output sio_d_oe
    );

    modport slave (
        input  lut_index,
        output lut_data,
        input  sio_c,
        input  sio_d_oe
    );

endinterface
`default_nettype wire

// File: rtl/sccb_tick_gen.sv
`default_nettype none
// ============================================================================
// Module : sccb_tick_gen
// Brief  : Quarter-bit tick divider; held cleared while en is low
// Rev    : 1.0
// ============================================================================
module sccb_tick_gen #(
    parameter int QDIV = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int            CW     = (QDIV > 1) ? $clog2(QDIV) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(QDIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!en || (cnt_q == C_LAST)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = en && (cnt_q == C_LAST);

endmodule
`default_nettype wire

// File: rtl/sccb_config_writer.sv
`default_nettype none
// ============================================================================
// Module : sccb_config_writer
// Brief  : Walks a register LUT and writes each entry as a 3-phase SCCB write
// Rev    : 1.0
// ============================================================================
module sccb_config_writer
    import sccb_pkg::*;
#(
    parameter int         CLK_HZ    = 25_000_000,
    parameter int         SCCB_HZ   = 100_000,
    parameter int         LUT_FIRST = 2,
    parameter int         LUT_LAST  = 166,
    parameter logic [7:0] DEV_ID    = DEF_DEV_ID,
    parameter int         PWRUP_CYC = 1_000_000,
    parameter int         GAP_CYC   = 5_000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    sccb_config_writer_if.master bus,
    output logic                 busy_o,
    output logic                 done_o
);

    localparam int QDIV    = CLK_HZ / (4 * SCCB_HZ);
    localparam int CNT_MAX = (PWRUP_CYC > GAP_CYC) ? PWRUP_CYC : GAP_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]     PWRUP_LAST = CNT_W'(PWRUP_CYC - 1);
    localparam logic [CNT_W-1:0]     GAP_LAST   = CNT_W'(GAP_CYC - 1);
    localparam logic [7:0]           IDX_FIRST  = 8'(LUT_FIRST);
    localparam logic [7:0]           IDX_LAST   = 8'(LUT_LAST);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT   = BIT_CNT_W'(FRAME_W - 1);
    localparam logic                 EMPTY_LUT  = (LUT_FIRST > LUT_LAST);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [1:0]           qtr_q, qtr_d;
    logic [BIT_CNT_W-1:0] bit_q, bit_d;
    logic [FRAME_W-1:0]   frame_q, frame_d;
    logic [7:0]           idx_q, idx_d;
    logic                 sio_c_q, sio_c_d;
    logic                 sio_d_oe_q, sio_d_oe_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 div_en;
    logic                 tick;

    assign div_en = (state_q == ST_START) || (state_q == ST_SHIFT) ||
                    (state_q == ST_ACK)   || (state_q == ST_STOP);

    sccb_tick_gen #(
        .QDIV (QDIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (div_en),
        .tick (tick)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        qtr_d   = qtr_q;
        bit_d   = bit_q;
        frame_d = frame_q;
        idx_d   = idx_q;

        case (state_q)
            ST_PWRUP: begin
                if (cnt_q == PWRUP_LAST) begin
                    cnt_d   = '0;
                    state_d = EMPTY_LUT ? ST_DONE : ST_LOAD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_LOAD: begin
                // ACK slots are loaded as 1 so the shared shift path leaves SDA released.
                frame_d = {DEV_ID, 1'b1, bus.lut_data[15:8], 1'b1, bus.lut_data[7:0], 1'b1};
                qtr_d   = 2'd0;
                bit_d   = '0;
                state_d = ST_START;
            end

            ST_START: begin
                if (tick) begin
                    if (qtr_q == 2'd2) begin
                        qtr_d   = 2'd0;
                        state_d = ST_SHIFT;
                    end else begin
                        qtr_d = qtr_q + 2'd1;
                    end
                end
            end

            ST_SHIFT, ST_ACK: begin
                if (tick) begin
                    if (qtr_q == 2'd3) begin
                        qtr_d   = 2'd0;
                        frame_d = {frame_q[FRAME_W-2:0], 1'b1};
                        bit_d   = bit_q + 1'b1;
                        if (bit_q == LAST_BIT) begin
                            state_d = ST_STOP;
                        end else if (is_ack_slot(bit_q + 1'b1)) begin
                            state_d = ST_ACK;
                        end else begin
                            state_d = ST_SHIFT;
                        end
                    end else begin
                        qtr_d = qtr_q + 2'd1;
                    end
                end
            end

            ST_STOP: begin
                if (tick) begin
                    if (qtr_q == 2'd2) begin
                        qtr_d   = 2'd0;
                        state_d = ST_GAP;
                    end else begin
                        qtr_d = qtr_q + 2'd1;
                    end
                end
            end

            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d = '0;
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + 8'd1;
                        state_d = ST_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_DONE: begin
                if (start_i) begin
                    idx_d   = IDX_FIRST;
                    state_d = EMPTY_LUT ? ST_DONE : ST_LOAD;
                end
            end

            default: state_d = ST_PWRUP;
        endcase

        // Outputs are decoded from the next state so the pins come straight from flops.
        {sio_c_d, sio_d_oe_d} = bus_levels(state_d, qtr_d, frame_d[FRAME_W-1]);
        busy_d = (state_d != ST_DONE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_PWRUP;
            cnt_q      <= '0;
            qtr_q      <= 2'd0;
            bit_q      <= '0;
            frame_q    <= '0;
            idx_q      <= IDX_FIRST;
            sio_c_q    <= 1'b1;
            sio_d_oe_q <= 1'b0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            qtr_q      <= qtr_d;
            bit_q      <= bit_d;
            frame_q    <= frame_d;
            idx_q      <= idx_d;
            sio_c_q    <= sio_c_d;
            sio_d_oe_q <= sio_d_oe_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.lut_index = idx_q;
    assign bus.sio_c     = sio_c_q;
    assign bus.sio_d_oe  = sio_d_oe_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;

endmodule
`default_nettype wire

// File: doc/sccb_config_writer.md
SCCB_CONFIG_WRITER -- requirements
Module: sccb_config_writer

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 25_000_000, meaning system clock frequency.
REQ-002 The block SHALL have parameter SCCB_HZ, default 100_000, meaning the SIO_C bit rate.
REQ-003 The block SHALL have parameter LUT_FIRST, default 2, meaning the first LUT index written.
REQ-004 The block SHALL have parameter LUT_LAST, default 166, meaning the last LUT index written (inclusive).
REQ-005 The block SHALL have parameter DEV_ID, default 8'h42, meaning the SCCB write slave address.
REQ-006 The block SHALL have parameter PWRUP_CYC, default 1_000_000, meaning the idle clocks after reset before the first write.
REQ-007 The block SHALL have parameter GAP_CYC, default 5_000, meaning the idle clocks between transactions.
REQ-008 Port clk  in  1  system clock; there is one clock, and all logic is rising-edge.
REQ-009 Port rst  in  1  reset; it is asynchronous and active-high.
REQ-010 Port start  in  1  a one-cycle pulse that restarts the sequence when in DONE.
REQ-011 Port lut_index  out  8  the address presented to the config LUT.
REQ-012 Port lut_data  in  16  {reg_addr[15:8], reg_val[7:0]} returned combinationally by the LUT.
REQ-013 Port sio_c  out  1  the SCCB clock, push-pull.
REQ-014 Port sio_d_oe  out  1  when 1, SIO_D is driven low; when 0, SIO_D is released (pull-up gives 1).
REQ-015 Port busy  out  1  high from reset release until DONE is reached.
REQ-016 Port done  out  1  high while in DONE.

Function
REQ-017 States SHALL be PWRUP, LOAD, START, SHIFT, ACK, STOP, GAP, and DONE.
REQ-018 A quarter-bit tick SHALL fire every QDIV = CLK_HZ/(4*SCCB_HZ) clocks, and the divider SHALL only run in START, SHIFT, ACK, and STOP.
REQ-019 PWRUP SHALL count PWRUP_CYC clocks with lut_index = LUT_FIRST, then go to LOAD.
REQ-020 LOAD SHALL take one clock to latch a 27-bit frame {DEV_ID, 1'b?, lut_data[15:8], 1'b?, lut_data[7:0], 1'b?}, with the ACK slots released.
REQ-021 START SHALL drive the condition SDA high to low while SCL is high, then drive SCL low one quarter later.
REQ-022 Each bit SHALL take 4 ticks: SDA changes at tick 0 with SCL low, SCL rises at tick 1, SCL is held high through tick 2, and SCL falls at tick 3. Bits SHALL be sent MSB first.
REQ-023 The ninth bit of each byte (ACK) SHALL release SDA, and the sampled value SHALL be ignored (SCCB don't-care).
REQ-024 STOP SHALL hold SDA low, raise SCL, then release SDA one quarter later. Each quarter step SHALL equal one tick.
REQ-025 GAP SHALL count GAP_CYC clocks. If lut_index == LUT_LAST it SHALL go to DONE; otherwise it SHALL increment lut_index and go to LOAD.
REQ-026 lut_index SHALL be stable from LOAD until the GAP exit, and the LUT SHALL be sampled only in LOAD.
REQ-027 In DONE, sio_c = 1, sio_d_oe = 0, busy = 0, and done = 1. A start pulse SHALL set lut_index = LUT_FIRST and go to LOAD, skipping PWRUP.
REQ-028 start SHALL be ignored in every state except DONE.
REQ-029 If LUT_FIRST > LUT_LAST, the block SHALL go from PWRUP directly to DONE with no bus activity.
REQ-030 Idle bus levels SHALL be sio_c = 1 and sio_d_oe = 0 in PWRUP, GAP, and DONE.

Reset
REQ-031 Asserting rst at any time, including mid-byte, SHALL immediately force PWRUP, counters to 0, lut_index = LUT_FIRST, sio_c = 1, sio_d_oe = 0, busy = 1, and done = 0.
REQ-032 After rst deasserts, the full PWRUP wait SHALL be repeated. No partial transaction SHALL resume.

Structure
REQ-033 A shared package sccb_pkg SHALL hold the state enum, the frame width (27), and the default DEV_ID.
REQ-034 The quarter-tick divider SHALL be the sub-module sccb_tick_gen (inputs clk, rst, en; output tick).
REQ-035 The LUT itself SHALL stay outside this block and be connected through lut_index/lut_data.

Verification
REQ-036 Bench parameters SHALL be CLK_HZ=4_000_000, SCCB_HZ=100_000 (QDIV=10), PWRUP_CYC=50, GAP_CYC=20, LUT_FIRST=2, LUT_LAST=4.
REQ-037 Scenario: a LUT model returns 16'h1204 at index 2 -> the bus monitor SHALL decode bytes 42, 12, 04 framed by START/STOP, with each bit lasting 40 clocks.
REQ-038 Scenario: full run, indices 2..4 -> exactly 3 transactions SHALL occur, lut_index SHALL step 2, 3, 4, and done SHALL rise after the third GAP, about 3*(27*40+60)+50+3*20 clocks.
REQ-039 Scenario: SDA pulled high in every ACK slot (NACK) -> the sequence SHALL complete identically.
REQ-040 Scenario: rst pulsed during bit 5 of the second byte -> sio_c = 1 and sio_d_oe = 0 SHALL hold within 0 clocks, followed by a 50-cycle wait, then a restart at index 2.
REQ-041 Scenario: start pulsed in SHIFT -> it SHALL be ignored; start pulsed in DONE -> indices 2..4 SHALL be rewritten with no PWRUP delay.
REQ-042 Scenario: LUT_FIRST=5, LUT_LAST=4 -> done SHALL be reached after 50 clocks, with sio_c never toggling.
